// File: rtl/onchip_mem_dual_port.sv
// Two-port Avalon-MM on-chip RAM over one true-dual-port array, with a
// post-reset clear sweep, waitrequest/readdatavalid handshakes and s1-priority write collisions.
module onchip_mem_dual_port #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 17,
  parameter int                DEPTH          = 98304,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               clear_wr;
  logic               ce;
  logic [DATA_W-1:0]  mem [DEPTH];

  // Index 0 is s1, index 1 is s2.
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][BE_W-1:0]   be;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][DATA_W-1:0] rd_word;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             cs, rd, wr;
  logic [1:0]             wait_req, wr_acc, rd_acc, in_range, rvalid;

  assign ce    = clken & ~reset_req;
  assign addr  = {s2_address, s1_address};
  assign be    = {s2_byteenable, s1_byteenable};
  assign wdata = {s2_writedata, s1_writedata};
  assign cs    = {s2_chipselect, s1_chipselect};
  assign rd    = {s2_read, s1_read};
  assign wr    = {s2_write, s1_write};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wait_req[p] = (state_q != ST_READY) | ~ce;
      wr_acc[p]   = cs[p] & wr[p] & ~wait_req[p];
      rd_acc[p]   = cs[p] & rd[p] & ~wr[p] & ~wait_req[p];
      in_range[p] = ({1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH));
      rd_word[p]  = in_range[p] ? mem[addr[p][IDX_W-1:0]] : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clear_wr  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (ce && !reset) begin
          clear_wr  = 1'b1;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array write: s2 lanes are applied first so s1 overrides on shared byte lanes.
  always_ff @(posedge clk) begin
    if (clear_wr) mem[clr_cnt_q] <= CLEAR_VALUE;
    for (int p = 1; p >= 0; p--) begin
      if (wr_acc[p] && in_range[p] && !reset) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[p][b]) mem[addr[p][IDX_W-1:0]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic [1:0][DATA_W-1:0] data_p0;
      logic [1:0]             vld_p0;

      // Stage p0: array output register, advances on accepted reads only.
      always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
          if (rd_acc[p]) data_p0[p] <= rd_word[p];
        end
      end

      // Stage p1: output register; a stalled p0 entry is released on the next ce cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p0 <= '0;
          rvalid <= '0;
          rdata  <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            if (ce) vld_p0[p] <= rd_acc[p];
            rvalid[p] <= ce & vld_p0[p];
            if (ce && vld_p0[p]) rdata[p] <= data_p0[p];
          end
        end
      end
    end else begin : g_lat1
      // Stage p0: read data captured directly at the acceptance edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          rvalid <= '0;
          rdata  <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            rvalid[p] <= rd_acc[p];
            if (rd_acc[p]) rdata[p] <= rd_word[p];
          end
        end
      end
    end
  endgenerate

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s1_waitrequest   = wait_req[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];
  assign s2_waitrequest   = wait_req[1];
  assign init_done        = (state_q == ST_READY);

endmodule

// File: tb/tb_onchip_mem_dual_port.sv
// Directed bench: two instances sharing all inputs, one with read latency 2 (a_*)
// and one with read latency 1 (b_*), both clearing 16 words to A5A5A5A5 after reset.
module tb_onchip_mem_dual_port;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
  logic a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest;
  logic a_init_done, b_init_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_mem_dual_port #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid),
    .s1_waitrequest(a_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid),
    .s2_waitrequest(a_s2_waitrequest),
    .init_done(a_init_done)
  );

  onchip_mem_dual_port #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid),
    .s1_waitrequest(b_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid),
    .s2_waitrequest(b_s2_waitrequest),
    .init_done(b_init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    s1_chipselect = 1'b1; s1_read = 1'b0; s1_write = 1'b1;
    s1_address = a; s1_writedata = d; s1_byteenable = b;
  endtask

  task automatic wr2(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    s2_chipselect = 1'b1; s2_read = 1'b0; s2_write = 1'b1;
    s2_address = a; s2_writedata = d; s2_byteenable = b;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = a;
  endtask

  task automatic rd2(input logic [AW-1:0] a);
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0; s2_address = a;
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    idle();
    s1_address = '0; s2_address = '0;
    s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    tick(); tick();

    chk("rst_rvalid", {31'b0, a_s1_readdatavalid}, 32'd0);
    chk("rst_rdata", a_s1_readdata, 32'd0);
    chk("rst_init_done", {31'b0, a_init_done}, 32'd0);
    chk("rst_waitreq", {31'b0, a_s1_waitrequest}, 32'd1);

    // Partial sweep, then reset restarts it from word 0.
    reset = 1'b0;
    repeat (8) tick();
    chk("mid_sweep_init", {31'b0, a_init_done}, 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      chk("sweep_init", {31'b0, a_init_done}, 32'd0);
      chk("sweep_wait", {31'b0, a_s2_waitrequest}, 32'd1);
      if (i == 4) begin
        clken = 1'b0; repeat (3) tick(); clken = 1'b1;
      end
      tick();
    end
    chk("init_done_a", {31'b0, a_init_done}, 32'd1);
    chk("init_done_b", {31'b0, b_init_done}, 32'd1);
    chk("ready_wait", {31'b0, a_s1_waitrequest}, 32'd0);

    // Back-to-back reads of all words.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) rd1(AW'(i)); else idle();
      tick();
      chk("sweep_rv_b", {31'b0, b_s1_readdatavalid}, {31'b0, (i < 16)});
      if (i < 16) chk("sweep_rd_b", b_s1_readdata, CV);
      chk("sweep_rv_a", {31'b0, a_s1_readdatavalid}, {31'b0, (i >= 1 && i <= 16)});
      if (i >= 1 && i <= 16) chk("sweep_rd_a", a_s1_readdata, CV);
    end

    // Latency with clken stall.
    wr1(5'd5, 32'hDEADBEEF, 4'hF); tick();
    rd1(5'd5); tick();
    idle(); clken = 1'b0; #1;
    chk("stall_acc_rv_b", {31'b0, b_s1_readdatavalid}, 32'd1);
    chk("stall_acc_rd_b", b_s1_readdata, 32'hDEADBEEF);
    chk("stall_acc_rv_a", {31'b0, a_s1_readdatavalid}, 32'd0);
    chk("stall_wait", {31'b0, a_s1_waitrequest}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rv_a", {31'b0, a_s1_readdatavalid}, 32'd0);
      chk("stall_rv_b", {31'b0, b_s1_readdatavalid}, 32'd0);
    end
    clken = 1'b1; tick();
    chk("stall_out_rv_a", {31'b0, a_s1_readdatavalid}, 32'd1);
    chk("stall_out_rd_a", a_s1_readdata, 32'hDEADBEEF);
    tick();
    chk("stall_nodup_a", {31'b0, a_s1_readdatavalid}, 32'd0);
    chk("stall_hold_a", a_s1_readdata, 32'hDEADBEEF);

    // Same-address write collision with byte lanes.
    wr1(5'd3, 32'h0, 4'hF); tick();
    wr1(5'd3, 32'h11223344, 4'b0011); wr2(5'd3, 32'hAABBCCDD, 4'b0110); tick();
    rd1(5'd3); rd2(5'd3); tick();
    idle();
    chk("coll_rv_b1", {31'b0, b_s1_readdatavalid}, 32'd1);
    chk("coll_rd_b1", b_s1_readdata, 32'h00BB3344);
    chk("coll_rd_b2", b_s2_readdata, 32'h00BB3344);
    tick();
    chk("coll_rd_a1", a_s1_readdata, 32'h00BB3344);
    chk("coll_rv_a2", {31'b0, a_s2_readdatavalid}, 32'd1);
    chk("coll_rd_a2", a_s2_readdata, 32'h00BB3344);

    // Read during write on the other port.
    wr1(5'd7, 32'h1, 4'hF); tick();
    wr1(5'd7, 32'h2, 4'hF); rd2(5'd7); tick();
    chk("rdw_rv_b", {31'b0, b_s2_readdatavalid}, 32'd1);
    chk("rdw_old_b", b_s2_readdata, 32'h1);
    idle(); rd2(5'd7); tick();
    chk("rdw_new_b", b_s2_readdata, 32'h2);
    chk("rdw_rv_a", {31'b0, a_s2_readdatavalid}, 32'd1);
    chk("rdw_old_a", a_s2_readdata, 32'h1);
    idle(); tick();
    chk("rdw_new_a", a_s2_readdata, 32'h2);

    // read and write together: write only.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1;
    s1_address = 5'd9; s1_writedata = 32'h55; s1_byteenable = 4'hF;
    tick(); idle();
    chk("rw_norv_b", {31'b0, b_s1_readdatavalid}, 32'd0);
    tick();
    chk("rw_norv_a", {31'b0, a_s1_readdatavalid}, 32'd0);
    rd1(5'd9); tick();
    chk("rw_rd_b", b_s1_readdata, 32'h55);
    idle(); tick();
    chk("rw_rv_a", {31'b0, a_s1_readdatavalid}, 32'd1);
    chk("rw_rd_a", a_s1_readdata, 32'h55);

    // Out-of-range address.
    wr1(5'd16, 32'hFFFFFFFF, 4'hF); tick();
    rd1(5'd16); tick();
    chk("oor_rv_b", {31'b0, b_s1_readdatavalid}, 32'd1);
    chk("oor_rd_b", b_s1_readdata, 32'h0);
    rd1(5'd0); tick();
    chk("oor_alias_b", b_s1_readdata, CV);
    chk("oor_rv_a", {31'b0, a_s1_readdatavalid}, 32'd1);
    chk("oor_rd_a", a_s1_readdata, 32'h0);
    idle(); tick();
    chk("oor_alias_a", a_s1_readdata, CV);

    // reset_req blocks both ports.
    reset_req = 1'b1; wr1(5'd0, 32'h12345678, 4'hF); rd2(5'd0); #1;
    chk("rreq_wait1", {31'b0, a_s1_waitrequest}, 32'd1);
    chk("rreq_wait2", {31'b0, a_s2_waitrequest}, 32'd1);
    tick();
    chk("rreq_norv_b2", {31'b0, b_s2_readdatavalid}, 32'd0);
    reset_req = 1'b0; idle(); rd1(5'd0); tick();
    chk("rreq_nowrite", b_s1_readdata, CV);
    idle(); tick();

    // Read in flight when reset arrives.
    rd1(5'd2); tick();
    idle(); reset = 1'b1; tick();
    chk("rst_q_rv", {31'b0, a_s1_readdatavalid}, 32'd0);
    chk("rst_q_rd", a_s1_readdata, 32'h0);
    reset = 1'b0; tick();
    chk("rst_q_rv2", {31'b0, a_s1_readdatavalid}, 32'd0);
    chk("rst_q_init", {31'b0, a_init_done}, 32'd0);
    chk("rst_q_wait", {31'b0, a_s1_waitrequest}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
